multi_ch_trig_capture: RTL and testbench
========================================

MULTI_CH_TRIG_CAPTURE -- requirements
Module: multi_ch_trig_capture

Interface
REQ-001 The block SHALL have parameter CH_NUM, default 2, number of sample channels (1..4).
REQ-002 The block SHALL have parameter DATA_W, default 8, bits per channel sample.
REQ-003 The block SHALL have parameter DEPTH, default 1024, samples captured per channel; it is a power of 2, at least 16.
REQ-004 The block SHALL have parameter AUTO_TO, default 1000000, auto-trigger timeout in accepted samples.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 sample_valid  in  1  sample_in is valid this cycle.
REQ-008 sample_in  in  CH_NUM*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W], unsigned.
REQ-009 arm  in  1  one-cycle start request.
REQ-010 trig_src  in  2  trigger channel index.
REQ-011 edge_mode  in  2  00 rising, 01 falling, 10 either, 11 force-only.
REQ-012 tri_level  in  DATA_W  trigger threshold.
REQ-013 hyst  in  DATA_W  hysteresis band.
REQ-014 pre_len  in  log2(DEPTH)  number of samples before the trigger.
REQ-015 auto_en  in  1  enables the auto-trigger timeout.
REQ-016 force_trig  in  1  immediate trigger request.
REQ-017 out_valid / out_ready / out_data (CH_NUM*DATA_W) / out_last  out/in/out/out  stream of the captured record.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 triggered  out  1  sticky from the trigger until the next arm.
REQ-020 trig_auto  out  1  the trigger came from the timeout.
REQ-021 state_out  out  3  IDLE=0, PREFILL=1, WAIT_TRIG=2, POST=3, DRAIN=4.

Function
REQ-022 The block SHALL latch trig_src, edge_mode, tri_level, hyst, pre_len and auto_en on the accepted arm and ignore later changes until the next arm.
REQ-023 The block SHALL accept arm only in IDLE and SHALL ignore arm in every other state.
REQ-024 The block SHALL write one DEPTH-entry ring buffer per channel, with a shared write pointer wrapping mod DEPTH, only on sample_valid in PREFILL, WAIT_TRIG and POST.
REQ-025 On arm the block SHALL go to PREFILL; when pre_len=0 it SHALL go directly to WAIT_TRIG.
REQ-026 PREFILL SHALL last until pre_len samples are written, then the block SHALL go to WAIT_TRIG.
REQ-027 Rising detection SHALL work as follows: the rearm flag sets when sample < sat(tri_level-hyst), and the trigger fires when the flag is set and sample >= tri_level.
REQ-028 Falling detection SHALL mirror rising: the flag sets when sample > sat(tri_level+hyst), and the trigger fires when sample <= tri_level.
REQ-029 sat() SHALL clamp the threshold result to the range 0..2^DATA_W-1.
REQ-030 In mode 10 the block SHALL fire on either the rising or the falling condition.
REQ-031 The rearm flags SHALL clear on arm and evaluate only on sample_valid cycles.
REQ-032 In WAIT_TRIG, force_trig SHALL fire immediately, and auto_en SHALL fire when the timeout counter reaches AUTO_TO.
REQ-033 The timeout counter SHALL count accepted samples in WAIT_TRIG only, starting from 0.
REQ-034 When an edge and force/auto coincide, the block SHALL produce a single trigger with trig_auto=0; trig_auto=1 only for a timeout-only trigger.
REQ-035 The trigger sample SHALL be written at address T, and the block SHALL set triggered and go to POST.
REQ-036 POST SHALL write DEPTH-pre_len-1 further samples, then the block SHALL go to DRAIN.
REQ-037 DRAIN SHALL read DEPTH entries starting at (T-pre_len) mod DEPTH, so that the trigger sample is at output index pre_len.
REQ-038 The stream SHALL follow valid/ready rules: out_data is stable while out_valid && !out_ready, and a beat transfers when both are high.
REQ-039 RAM read latency SHALL be 1 cycle; out_valid SHALL first rise 2 cycles after DRAIN entry.
REQ-040 out_last SHALL be high only on beat DEPTH-1; after that beat the block SHALL return to IDLE.
REQ-041 Samples arriving in DRAIN SHALL be discarded.

Reset
REQ-042 rst SHALL force state IDLE with all pointers and counters at 0.
REQ-043 During rst, out_valid, out_last, busy, triggered and trig_auto SHALL be 0 and out_data SHALL be 0.
REQ-044 Reset mid-capture SHALL abort with no further output; buffer contents are don't-care.

Verification
REQ-045 DEPTH=16, pre_len=4, rising, level 128, hyst 8, ramp 100..200 -> triggered; index 4 = first sample >=128; index 3 <128; 16 beats; out_last on beat 15.
REQ-046 Falling mode, samples 130,125,110,140,126 with level 128, hyst 8 -> no trigger at 125 (flag clear); trigger at 126 after 140 sets the flag.
REQ-047 auto_en=1, AUTO_TO=20, constant input 50 -> trigger on the 20th WAIT_TRIG sample, trig_auto=1, 16 beats drained.
REQ-048 out_ready toggled 1-0-0-1 during DRAIN -> no beat lost or duplicated; out_data held while stalled; arm pulsed mid-DRAIN is ignored.
REQ-049 pre_len=0 with force_trig and a rising edge in the same cycle -> PREFILL skipped, trigger at index 0, trig_auto=0.
REQ-050 rst asserted in POST -> all outputs 0 on the next edge; a following arm runs a clean capture.

Source files
------------

// File: rtl/multi_ch_trig_capture_if.sv
// Captured-record output stream: valid/ready handshake carrying one sample of
// every channel per beat, with out_last marking the final beat of the record.
interface multi_ch_trig_capture_if #(
  parameter int DATA_BITS = 16
);
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_BITS-1:0] out_data;
  logic                 out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/multi_ch_trig_capture.sv
// Multi-channel triggered capture: per-channel ring buffers with pre-trigger history,
// edge/force/auto triggering, and a 2-stage read pipeline draining the record.
module multi_ch_trig_capture #(
  parameter int CH_NUM  = 2,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 1024,
  parameter int AUTO_TO = 1000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_valid,
  input  logic [CH_NUM*DATA_W-1:0]   sample_in,
  input  logic                       arm,
  input  logic [1:0]                 trig_src,
  input  logic [1:0]                 edge_mode,
  input  logic [DATA_W-1:0]          tri_level,
  input  logic [DATA_W-1:0]          hyst,
  input  logic [$clog2(DEPTH)-1:0]   pre_len,
  input  logic                       auto_en,
  input  logic                       force_trig,
  multi_ch_trig_capture_if.master    out_s,
  output logic                       busy,
  output logic                       triggered,
  output logic                       trig_auto,
  output logic [2:0]                 state_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(AUTO_TO + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PREFILL   = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    DRAIN     = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [1:0]        trig_src_q, edge_mode_q;
  logic [DATA_W-1:0] level_q, hyst_q;
  logic [AW-1:0]     pre_len_q;
  logic              auto_en_q;

  logic [AW-1:0]     wr_ptr, t_addr, rd_ptr;
  logic [CW-1:0]     cnt, rd_left;
  logic [TW-1:0]     to_cnt;
  logic              rise_flag, fall_flag;

  logic [DATA_W-1:0] trig_sample, thr_lo, thr_hi;
  logic [DATA_W:0]   hi_sum;
  logic              rise_hit, fall_hit, edge_hit, edge_fire, auto_fire, fire;
  logic              wr_en, rd_issue, adv_out, adv_ram, beat_done;

  logic [DATA_W-1:0]        mem [CH_NUM][DEPTH];
  logic [CH_NUM*DATA_W-1:0] ram_q, out_data_q;
  logic                     ram_v, ram_last, out_valid_q, out_last_q;

  always_comb begin
    trig_sample = sample_in[DATA_W-1:0];
    for (int c = 0; c < CH_NUM; c++)
      if (trig_src_q == 2'(c)) trig_sample = sample_in[c*DATA_W +: DATA_W];
  end

  // Hysteresis thresholds clamp at the ends of the sample range.
  assign hi_sum = {1'b0, level_q} + {1'b0, hyst_q};
  assign thr_hi = hi_sum[DATA_W] ? '1 : hi_sum[DATA_W-1:0];
  assign thr_lo = (level_q > hyst_q) ? (level_q - hyst_q) : '0;

  assign rise_hit = rise_flag && (trig_sample >= level_q);
  assign fall_hit = fall_flag && (trig_sample <= level_q);

  always_comb begin
    edge_hit = 1'b0;
    case (edge_mode_q)
      2'b00:   edge_hit = rise_hit;
      2'b01:   edge_hit = fall_hit;
      2'b10:   edge_hit = rise_hit || fall_hit;
      default: edge_hit = 1'b0;
    endcase
  end

  assign edge_fire = sample_valid && edge_hit;
  assign auto_fire = auto_en_q && sample_valid && (to_cnt == TW'(AUTO_TO - 1));
  assign fire      = (state == WAIT_TRIG) && (edge_fire || force_trig || auto_fire);

  assign wr_en = sample_valid &&
                 ((state == PREFILL) || (state == WAIT_TRIG) || ((state == POST) && (cnt != '0)));

  assign adv_out   = !out_valid_q || out_s.out_ready;
  assign adv_ram   = !ram_v || adv_out;
  assign rd_issue  = (state == DRAIN) && (rd_left != '0) && adv_ram;
  assign beat_done = out_valid_q && out_s.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (arm) state_nxt = (pre_len == '0) ? WAIT_TRIG : PREFILL;
      PREFILL:   if (sample_valid && (cnt == CW'(1))) state_nxt = WAIT_TRIG;
      WAIT_TRIG: if (fire) state_nxt = POST;
      POST:      if ((cnt == '0) || (sample_valid && (cnt == CW'(1)))) state_nxt = DRAIN;
      DRAIN:     if (beat_done && out_last_q) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Capture-side control: config latch, counters, rearm flags and trigger bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_src_q  <= '0;
      edge_mode_q <= '0;
      level_q     <= '0;
      hyst_q      <= '0;
      pre_len_q   <= '0;
      auto_en_q   <= 1'b0;
      wr_ptr      <= '0;
      t_addr      <= '0;
      cnt         <= '0;
      to_cnt      <= '0;
      rise_flag   <= 1'b0;
      fall_flag   <= 1'b0;
      triggered   <= 1'b0;
      trig_auto   <= 1'b0;
    end else begin
      if ((state == IDLE) && arm) begin
        trig_src_q  <= trig_src;
        edge_mode_q <= edge_mode;
        level_q     <= tri_level;
        hyst_q      <= hyst;
        pre_len_q   <= pre_len;
        auto_en_q   <= auto_en;
        wr_ptr      <= '0;
        cnt         <= CW'(pre_len);
        to_cnt      <= '0;
        rise_flag   <= 1'b0;
        fall_flag   <= 1'b0;
        triggered   <= 1'b0;
        trig_auto   <= 1'b0;
      end
      if (((state == PREFILL) || (state == WAIT_TRIG)) && sample_valid) begin
        rise_flag <= rise_flag || (trig_sample < thr_lo);
        fall_flag <= fall_flag || (trig_sample > thr_hi);
      end
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      case (state)
        PREFILL: if (sample_valid) cnt <= cnt - CW'(1);
        WAIT_TRIG: begin
          if (sample_valid) to_cnt <= to_cnt + TW'(1);
          // A force without a sample makes the next accepted sample the trigger sample.
          if (fire) begin
            t_addr    <= wr_ptr;
            triggered <= 1'b1;
            trig_auto <= auto_fire && !edge_fire && !force_trig;
            cnt       <= sample_valid ? (CW'(DEPTH - 1) - CW'(pre_len_q))
                                      : (CW'(DEPTH) - CW'(pre_len_q));
          end
        end
        POST: if (sample_valid && (cnt != '0)) cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      for (int c = 0; c < CH_NUM; c++) mem[c][wr_ptr] <= sample_in[c*DATA_W +: DATA_W];
    if (rd_issue)
      for (int c = 0; c < CH_NUM; c++) ram_q[c*DATA_W +: DATA_W] <= mem[c][rd_ptr];
  end

  // Drain pipeline: RAM output stage feeding a stallable output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr      <= '0;
      rd_left     <= '0;
      ram_v       <= 1'b0;
      ram_last    <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if ((state == POST) && (state_nxt == DRAIN)) begin
        rd_ptr  <= t_addr - pre_len_q;
        rd_left <= CW'(DEPTH);
      end else if (rd_issue) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_left <= rd_left - CW'(1);
      end
      if (adv_ram) begin
        ram_v    <= rd_issue;
        ram_last <= rd_issue && (rd_left == CW'(1));
      end
      if (adv_out) begin
        out_valid_q <= ram_v;
        out_last_q  <= ram_v && ram_last;
        if (ram_v) out_data_q <= ram_q;
      end
    end
  end

  assign out_s.out_valid = out_valid_q;
  assign out_s.out_last  = out_last_q;
  assign out_s.out_data  = out_data_q;
  assign busy            = (state != IDLE);
  assign state_out       = state;

endmodule

// File: tb/tb_multi_ch_trig_capture.sv
// Directed bench for multi_ch_trig_capture: drives capture scenarios and scores the
// drained record against the samples it drove.
module tb_multi_ch_trig_capture;

  localparam int CH_NUM  = 2;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 16;
  localparam int AUTO_TO = 20;
  localparam int AW      = 4;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     sample_valid = 1'b0;
  logic [CH_NUM*DATA_W-1:0] sample_in = '0;
  logic                     arm = 1'b0;
  logic [1:0]               trig_src = '0;
  logic [1:0]               edge_mode = '0;
  logic [DATA_W-1:0]        tri_level = '0;
  logic [DATA_W-1:0]        hyst = '0;
  logic [AW-1:0]            pre_len = '0;
  logic                     auto_en = 1'b0;
  logic                     force_trig = 1'b0;
  logic                     busy, triggered, trig_auto;
  logic [2:0]               state_out;

  multi_ch_trig_capture_if #(.DATA_BITS(CH_NUM*DATA_W)) out_s ();

  multi_ch_trig_capture #(
    .CH_NUM(CH_NUM), .DATA_W(DATA_W), .DEPTH(DEPTH), .AUTO_TO(AUTO_TO)
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
    .arm(arm), .trig_src(trig_src), .edge_mode(edge_mode), .tri_level(tri_level),
    .hyst(hyst), .pre_len(pre_len), .auto_en(auto_en), .force_trig(force_trig),
    .out_s(out_s), .busy(busy), .triggered(triggered), .trig_auto(trig_auto),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] hist[$];
  logic [15:0] sb[$];
  logic [15:0] got[DEPTH];
  int trig_idx;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] sample_for(input int test, input int k);
    logic [7:0] v;
    v = 8'd60;
    case (test)
      0, 3: v = 8'(100 + k);
      1: case (k)
           0, 1: v = 8'd128;
           2: v = 8'd130;
           3: v = 8'd125;
           4: v = 8'd110;
           5: v = 8'd140;
           6: v = 8'd126;
           default: v = 8'd60;
         endcase
      2: v = 8'd50;
      default: v = (k == 0) ? 8'd100 : (k == 1) ? 8'd150 : 8'(90 + k);
    endcase
    return v;
  endfunction

  task automatic applyStimulus(input logic [7:0] c0, input logic [7:0] c1, input logic frc);
    sample_valid = 1'b1;
    sample_in    = {c1, c0};
    force_trig   = frc;
    hist.push_back({c1, c0});
    tick();
    sample_valid = 1'b0;
    force_trig   = 1'b0;
  endtask

  // Arms a capture, then scrambles the config inputs so only the latched copy can matter.
  task automatic arm_capture(input logic [1:0] src, input logic [1:0] mode, input logic [7:0] lvl,
                             input logic [7:0] hy, input logic [3:0] pre, input logic aen);
    trig_src = src; edge_mode = mode; tri_level = lvl; hyst = hy; pre_len = pre; auto_en = aen;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    hist.delete();
    trig_src = 2'd1; edge_mode = mode ^ 2'b11; tri_level = ~lvl; hyst = 8'd0;
    pre_len = ~pre; auto_en = ~aen;
  endtask

  task automatic run_to_drain(input int test, input int frc_idx, output int tidx);
    tidx = -1;
    for (int n = 0; n < 80 && state_out != 3'd4; n++) begin
      int k;
      k = hist.size();
      applyStimulus(sample_for(test, k), 8'(k * 7 + test * 31), k == frc_idx);
      if (triggered && tidx < 0) tidx = k;
    end
  endtask

  task automatic expect_record(input int tidx, input int pre);
    sb.delete();
    if (tidx >= pre)
      for (int i = 0; i < DEPTH; i++) sb.push_back(hist[tidx - pre + i]);
  endtask

  task automatic checkOutput(input bit stall_mode, input bit arm_mid);
    int beats;
    int cyc;
    bit stalled;
    logic [15:0] held;
    logic [15:0] exp_beat;
    beats = 0; cyc = 0; stalled = 1'b0; held = '0;
    sample_valid = 1'b1;
    sample_in    = 16'hEEEE;
    while (beats < DEPTH && cyc < 200) begin
      out_s.out_ready = stall_mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      arm = arm_mid && (cyc == 5);
      if (cyc < 2) check("first beat latency idle", 32'(out_s.out_valid), 32'd0);
      if (cyc == 2) check("first beat latency valid", 32'(out_s.out_valid), 32'd1);
      if (stalled) begin
        check("stall valid held", 32'(out_s.out_valid), 32'd1);
        check("stall data held", 32'(out_s.out_data), 32'(held));
        stalled = 1'b0;
      end
      if (out_s.out_valid) begin
        if (out_s.out_ready) begin
          exp_beat = (sb.size() > 0) ? sb.pop_front() : 16'hDEAD;
          check($sformatf("beat %0d data", beats), 32'(out_s.out_data), 32'(exp_beat));
          check($sformatf("beat %0d last", beats), 32'(out_s.out_last), 32'(beats == DEPTH - 1));
          got[beats] = out_s.out_data;
          beats++;
        end else begin
          stalled = 1'b1;
          held = out_s.out_data;
        end
      end
      tick();
      cyc++;
    end
    out_s.out_ready = 1'b0;
    arm = 1'b0;
    sample_valid = 1'b0;
    check("beat count", 32'(beats), 32'(DEPTH));
    check("state idle after record", 32'(state_out), 32'd0);
    check("valid low after record", 32'(out_s.out_valid), 32'd0);
  endtask

  initial begin
    out_s.out_ready = 1'b0;

    // Reset state
    tick(); tick();
    check("reset state", 32'(state_out), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset out_valid", 32'(out_s.out_valid), 32'd0);
    check("reset out_last", 32'(out_s.out_last), 32'd0);
    check("reset out_data", 32'(out_s.out_data), 32'd0);
    check("reset triggered", 32'(triggered), 32'd0);
    check("reset trig_auto", 32'(trig_auto), 32'd0);
    rst = 1'b0;
    tick();

    // Rising ramp with pre-trigger history
    arm_capture(2'd0, 2'b00, 8'd128, 8'd8, 4'd4, 1'b0);
    check("ramp state prefill", 32'(state_out), 32'd1);
    check("ramp busy", 32'(busy), 32'd1);
    run_to_drain(0, -1, trig_idx);
    check("ramp trigger index", 32'(trig_idx), 32'd28);
    check("ramp trig_auto", 32'(trig_auto), 32'd0);
    expect_record(trig_idx, 4);
    checkOutput(1'b0, 1'b0);
    check("ramp index 4 level", 32'(got[4][7:0]), 32'd128);
    check("ramp index 3 below", 32'(got[3][7:0] < 8'd128), 32'd1);

    // Falling with rearm hysteresis, stalled drain and ignored arm
    arm_capture(2'd0, 2'b01, 8'd128, 8'd8, 4'd2, 1'b0);
    run_to_drain(1, -1, trig_idx);
    check("fall trigger index", 32'(trig_idx), 32'd6);
    check("fall trig_auto", 32'(trig_auto), 32'd0);
    expect_record(trig_idx, 2);
    checkOutput(1'b1, 1'b1);

    // Auto-trigger timeout
    arm_capture(2'd0, 2'b00, 8'd128, 8'd8, 4'd4, 1'b1);
    run_to_drain(2, -1, trig_idx);
    check("auto trigger index", 32'(trig_idx), 32'd23);
    check("auto trig_auto", 32'(trig_auto), 32'd1);
    expect_record(trig_idx, 4);
    checkOutput(1'b0, 1'b0);

    // Reset during POST
    arm_capture(2'd0, 2'b00, 8'd200, 8'd8, 4'd4, 1'b0);
    for (int k = 0; k < 8; k++) applyStimulus(8'(100 + k), 8'(k), k == 6);
    check("abort state post", 32'(state_out), 32'd3);
    rst = 1'b1;
    tick();
    check("abort state", 32'(state_out), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort triggered", 32'(triggered), 32'd0);
    check("abort trig_auto", 32'(trig_auto), 32'd0);
    check("abort out_valid", 32'(out_s.out_valid), 32'd0);
    check("abort out_data", 32'(out_s.out_data), 32'd0);
    rst = 1'b0;
    out_s.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("abort no output", 32'(out_s.out_valid), 32'd0);
    out_s.out_ready = 1'b0;

    // pre_len=0 with force and rising edge together
    arm_capture(2'd0, 2'b00, 8'd128, 8'd8, 4'd0, 1'b0);
    check("zero pre skips prefill", 32'(state_out), 32'd2);
    run_to_drain(4, 1, trig_idx);
    check("force trigger index", 32'(trig_idx), 32'd1);
    check("force trig_auto", 32'(trig_auto), 32'd0);
    expect_record(trig_idx, 0);
    checkOutput(1'b0, 1'b0);
    check("force index 0 sample", 32'(got[0][7:0]), 32'd150);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
